// File: rtl/gs_ddram_bridge.sv
// Byte-wide General Sound memory port mapped onto the 64-bit Avalon DDR3 port,
// with a single-word write-through read cache for sequential byte reads.
module gs_ddram_bridge #(
    parameter int          ADDR_W    = 21,
    parameter logic [28:0] BASE_WORD = 29'h0600_0000
) (
    input  logic              DDRAM_CLK,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              rd,
    input  logic              we,
    output logic              ready,
    input  logic              DDRAM_BUSY,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [28:0]       DDRAM_ADDR,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic              DDRAM_RD,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    output logic              DDRAM_WE
);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} state_t;

    localparam int WORD_W = ADDR_W - 3;

    state_t              state, state_nxt;
    logic                old_rd, old_we;
    logic                ready_q, ready_nxt;
    logic                ddr_rd_q, ddr_rd_nxt;
    logic                ddr_we_q, ddr_we_nxt;
    logic [WORD_W-1:0]   lat_word, lat_word_nxt;
    logic [7:0]          be_q, be_nxt;
    logic [63:0]         din_q, din_nxt;
    logic [63:0]         cache, cache_nxt;
    logic [WORD_W-1:0]   tag, tag_nxt;
    logic                valid, valid_nxt;

    logic                start_rd, start_we, hit;
    logic [WORD_W-1:0]   addr_word;

    assign addr_word = addr[ADDR_W-1:3];
    assign start_rd  = rd & ~old_rd;
    assign start_we  = we & ~old_we;
    assign hit       = valid && (tag == addr_word);

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            old_rd   <= 1'b0;
            old_we   <= 1'b0;
            ready_q  <= 1'b1;
            ddr_rd_q <= 1'b0;
            ddr_we_q <= 1'b0;
            lat_word <= '0;
            be_q     <= 8'hFF;
            din_q    <= '0;
            cache    <= '0;
            tag      <= '0;
            valid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            old_rd   <= rd;
            old_we   <= we;
            ready_q  <= ready_nxt;
            ddr_rd_q <= ddr_rd_nxt;
            ddr_we_q <= ddr_we_nxt;
            lat_word <= lat_word_nxt;
            be_q     <= be_nxt;
            din_q    <= din_nxt;
            cache    <= cache_nxt;
            tag      <= tag_nxt;
            valid    <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ready_nxt    = ready_q;
        ddr_rd_nxt   = ddr_rd_q;
        ddr_we_nxt   = ddr_we_q;
        lat_word_nxt = lat_word;
        be_nxt       = be_q;
        din_nxt      = din_q;
        cache_nxt    = cache;
        tag_nxt      = tag;
        valid_nxt    = valid;
        case (state)
            IDLE: begin
                // A simultaneous rd/we edge is treated as a write; the read is dropped.
                if (start_we) begin
                    lat_word_nxt = addr_word;
                    be_nxt       = 8'd1 << addr[2:0];
                    din_nxt      = {8{din}};
                    ddr_we_nxt   = 1'b1;
                    ready_nxt    = 1'b0;
                    state_nxt    = WR_REQ;
                    if (hit)
                        cache_nxt[{addr[2:0], 3'b000} +: 8] = din;
                end else if (start_rd && !hit) begin
                    lat_word_nxt = addr_word;
                    be_nxt       = 8'hFF;
                    ddr_rd_nxt   = 1'b1;
                    ready_nxt    = 1'b0;
                    state_nxt    = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!DDRAM_BUSY) begin
                    ddr_rd_nxt = 1'b0;
                    state_nxt  = RD_DATA;
                end
            end
            RD_DATA: begin
                if (DDRAM_DOUT_READY) begin
                    cache_nxt = DDRAM_DOUT;
                    tag_nxt   = lat_word;
                    valid_nxt = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                if (!DDRAM_BUSY) begin
                    ddr_we_nxt = 1'b0;
                    ready_nxt  = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dout           = cache[{addr[2:0], 3'b000} +: 8];
    assign ready          = ready_q;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = BASE_WORD + 29'(lat_word);
    assign DDRAM_RD       = ddr_rd_q;
    assign DDRAM_WE       = ddr_we_q;
    assign DDRAM_BE       = be_q;
    assign DDRAM_DIN      = din_q;

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Directed bench for gs_ddram_bridge: cycle table for read/write/cache paths,
// plus hand sequences for reset and reset during an outstanding read.
module tb_gs_ddram_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [20:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd, we, ready;
    logic        busy;
    logic [7:0]  burstcnt;
    logic [28:0] d_addr;
    logic [63:0] d_dout;
    logic        d_vld;
    logic        d_rd;
    logic [63:0] d_din;
    logic [7:0]  d_be;
    logic        d_we;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gs_ddram_bridge dut (
        .DDRAM_CLK(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
        .rd(rd), .we(we), .ready(ready), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt),
        .DDRAM_ADDR(d_addr), .DDRAM_DOUT(d_dout), .DDRAM_DOUT_READY(d_vld),
        .DDRAM_RD(d_rd), .DDRAM_DIN(d_din), .DDRAM_BE(d_be), .DDRAM_WE(d_we)
    );

    typedef struct {
        logic        rd, we;
        logic [20:0] addr;
        logic [7:0]  din;
        logic        busy, vld;
        logic [63:0] ddout;
        logic        e_ready, e_rd, e_we;
        logic [7:0]  e_dout;
        logic [28:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_din;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [20:0] a,
                                input logic [7:0] di, input logic b, input logic v,
                                input logic [63:0] dd, input logic er, input logic erd,
                                input logic ewe, input logic [7:0] edo, input logic [28:0] ea,
                                input logic [7:0] ebe, input logic [63:0] edi);
        vec_t t;
        t.rd = r; t.we = w; t.addr = a; t.din = di; t.busy = b; t.vld = v; t.ddout = dd;
        t.e_ready = er; t.e_rd = erd; t.e_we = ewe; t.e_dout = edo; t.e_addr = ea;
        t.e_be = ebe; t.e_din = edi;
        return t;
    endfunction

    initial begin
        localparam logic [63:0] W1 = 64'h0807_0605_0403_0201;
        localparam logic [63:0] W2 = 64'hF1E2_D3C4_B5A6_9788;
        localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;
        localparam logic [63:0] S5 = 64'h5555_5555_5555_5555;
        //           rd we addr       din   bsy vld ddout  rdy drd dwe dout  ddr_addr      be     din
        tbl[0]  = mk(1, 0, 21'h00005, 8'h00, 1, 0, 64'h0, 0, 1, 0, 8'h00, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[1]  = mk(1, 0, 21'h00005, 8'h00, 1, 0, 64'h0, 0, 1, 0, 8'h00, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[2]  = mk(1, 0, 21'h00005, 8'h00, 1, 0, 64'h0, 0, 1, 0, 8'h00, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[3]  = mk(1, 0, 21'h00005, 8'h00, 1, 0, 64'h0, 0, 1, 0, 8'h00, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[4]  = mk(1, 0, 21'h00005, 8'h00, 0, 0, 64'h0, 0, 0, 0, 8'h00, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[5]  = mk(1, 0, 21'h00005, 8'h00, 0, 1, W1,    1, 0, 0, 8'h06, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[6]  = mk(0, 0, 21'h00005, 8'h00, 0, 0, 64'h0, 1, 0, 0, 8'h06, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[7]  = mk(1, 0, 21'h00003, 8'h00, 0, 0, 64'h0, 1, 0, 0, 8'h04, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[8]  = mk(0, 0, 21'h00003, 8'h00, 0, 0, 64'h0, 1, 0, 0, 8'h04, 29'h0600_0000, 8'hFF, 64'h0);
        tbl[9]  = mk(0, 1, 21'h00002, 8'hAA, 1, 0, 64'h0, 0, 0, 1, 8'hAA, 29'h0600_0000, 8'h04, AA);
        tbl[10] = mk(0, 1, 21'h00002, 8'hAA, 1, 0, 64'h0, 0, 0, 1, 8'hAA, 29'h0600_0000, 8'h04, AA);
        tbl[11] = mk(0, 1, 21'h00002, 8'hAA, 0, 0, 64'h0, 1, 0, 0, 8'hAA, 29'h0600_0000, 8'h04, AA);
        tbl[12] = mk(1, 0, 21'h00002, 8'h00, 0, 0, 64'h0, 1, 0, 0, 8'hAA, 29'h0600_0000, 8'h04, AA);
        tbl[13] = mk(0, 0, 21'h00002, 8'h00, 0, 0, 64'h0, 1, 0, 0, 8'hAA, 29'h0600_0000, 8'h04, AA);
        tbl[14] = mk(1, 0, 21'h1FFFFF, 8'h00, 0, 0, 64'h0, 0, 1, 0, 8'h08, 29'h0603_FFFF, 8'hFF, AA);
        tbl[15] = mk(1, 0, 21'h1FFFFF, 8'h00, 0, 0, 64'h0, 0, 0, 0, 8'h08, 29'h0603_FFFF, 8'hFF, AA);
        tbl[16] = mk(1, 0, 21'h1FFFFF, 8'h00, 0, 1, W2,    1, 0, 0, 8'hF1, 29'h0603_FFFF, 8'hFF, AA);
        tbl[17] = mk(0, 0, 21'h1FFFFF, 8'h00, 0, 0, 64'h0, 1, 0, 0, 8'hF1, 29'h0603_FFFF, 8'hFF, AA);
        tbl[18] = mk(1, 1, 21'h00010, 8'h55, 1, 0, 64'h0, 0, 0, 1, 8'h88, 29'h0600_0002, 8'h01, S5);
        tbl[19] = mk(1, 1, 21'h00010, 8'h55, 0, 0, 64'h0, 1, 0, 0, 8'h88, 29'h0600_0002, 8'h01, S5);
        // Stray data-valid while idle must not disturb the cached word.
        tbl[20] = mk(0, 0, 21'h00010, 8'h00, 0, 1, 64'hDEAD_BEEF_0000_1111,
                     1, 0, 0, 8'h88, 29'h0600_0002, 8'h01, S5);

        reset_n = 1'b0; addr = '0; din = '0; rd = 0; we = 0; busy = 0; d_vld = 0; d_dout = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_ready", ready, 1);
        chk("reset_ddram_rd", d_rd, 0);
        chk("reset_ddram_we", d_we, 0);
        chk("reset_dout", dout, 0);
        chk("burstcnt", burstcnt, 8'd1);

        for (int i = 0; i < 21; i++) begin
            rd = tbl[i].rd; we = tbl[i].we; addr = tbl[i].addr; din = tbl[i].din;
            busy = tbl[i].busy; d_vld = tbl[i].vld; d_dout = tbl[i].ddout;
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready", i), ready, tbl[i].e_ready);
            chk($sformatf("v%0d_ddram_rd", i), d_rd, tbl[i].e_rd);
            chk($sformatf("v%0d_ddram_we", i), d_we, tbl[i].e_we);
            chk($sformatf("v%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("v%0d_ddram_addr", i), d_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_be", i), d_be, tbl[i].e_be);
            chk($sformatf("v%0d_din", i), d_din, tbl[i].e_din);
        end

        // Reset while a read is waiting for data.
        rd = 0; we = 0; d_vld = 0; busy = 0; addr = 21'h00040;
        @(posedge clk); #1;
        rd = 1;
        @(posedge clk); #1;
        chk("abort_issue_rd", d_rd, 1);
        @(posedge clk); #1;
        chk("abort_in_rd_data", d_rd, 0);
        chk("abort_ready_low", ready, 0);
        reset_n = 1'b0;
        #1;
        chk("abort_async_ready", ready, 1);
        chk("abort_async_rd", d_rd, 0);
        chk("abort_async_dout", dout, 0);
        rd = 0;
        @(posedge clk); #1 reset_n = 1'b1;
        d_vld = 1; d_dout = 64'h1122_3344_5566_7788;
        @(posedge clk); #1;
        d_vld = 0;
        chk("late_vld_ready", ready, 1);
        chk("late_vld_dout", dout, 0);
        rd = 1;
        @(posedge clk); #1;
        chk("reissue_rd", d_rd, 1);
        chk("reissue_ready", ready, 0);
        chk("reissue_addr", d_addr, 29'h0600_0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
